// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - command/response and APB bus bundle for apb_master
//
// Purpose: groups the local command port, the response port and the APB
// requester-side signals of apb_master into one bundle.
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata  command handshake
//   rsp_valid/rsp_rdata/rsp_err/rsp_timeout           response pulse and fields
//   psel/penable/pwrite/paddr/pwdata                  APB requester outputs
//   prdata/pready/pslverr                             APB responder returns
// Modports: master (the apb_master block), slave (command source + responder).
interface apb_master_if #(
  parameter int addrWidth = 2,
  parameter int dataWidth = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [addrWidth-1:0] cmd_addr;
  logic [dataWidth-1:0] cmd_wdata;
  logic                 rsp_valid;
  logic [dataWidth-1:0] rsp_rdata;
  logic                 rsp_err;
  logic                 rsp_timeout;
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [addrWidth-1:0] paddr;
  logic [dataWidth-1:0] pwdata;
  logic [dataWidth-1:0] prdata;
  logic                 pready;
  logic                 pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-beat APB requester with access timeout
//
// Purpose: accepts one command at a time, runs SETUP then ACCESS on APB,
// tolerates wait states, aborts after timeoutCycles ACCESS cycles (0 = never)
// and returns a one-cycle response pulse with read data and error status.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    apb_master_if.master: command, response and APB signals
module apb_master #(
  parameter int addrWidth     = 2,
  parameter int dataWidth     = 8,
  parameter int timeoutCycles = 16
) (
  input  logic           clk,
  input  logic           reset,
  apb_master_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // The counter only has to reach timeoutCycles-1: the abort is decided in the
  // ACCESS cycle that would make it the timeoutCycles-th stalled cycle.
  localparam int CNT_W = (timeoutCycles > 2) ? $clog2(timeoutCycles) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((timeoutCycles > 0) ? timeoutCycles - 1 : 0);
  localparam bit TO_EN = (timeoutCycles != 0);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [addrWidth-1:0] paddr_q, paddr_d;
  logic [dataWidth-1:0] pwdata_q, pwdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [dataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
  logic                 timeout_hit;

  // pready wins over the limit on the same cycle.
  assign timeout_hit = TO_EN && !bus.pready && (cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          rsp_err_d     = bus.pslverr;
          rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (timeout_hit) begin
          rsp_err_d     = 1'b1;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned
    // with the state they belong to.
    cmd_ready_d = (state_d == IDLE);
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b1;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule
